// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets, STATUS bit positions and bus write-length encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_BAUD   = 4'h8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_PARITY  = 4;
    localparam int STAT_LVL_LSB = 8;

    localparam logic [2:0] WL_BYTE = 3'd1;
    localparam logic [2:0] WL_HALF = 3'd2;
    localparam logic [2:0] WL_WORD = 3'd4;

    function automatic logic wl_valid(input logic [2:0] wl);
        return (wl == WL_BYTE) || (wl == WL_HALF) || (wl == WL_WORD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; full/empty reflect the state
// before any same-cycle push or pop, so a push while full is always dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = (level_o == LVL_W'(DEPTH));
    assign empty_o    = (level_o == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first) with TX FIFO and baud divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module bus_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_bus_address,
    input  logic [31:0] i_bus_wr_data,
    input  logic        i_bus_wr_enable,
    input  logic [2:0]  i_bus_write_length,
    output logic [31:0] o_bus_read_data,
    output logic        o_bus_hit,
    output logic        o_tx
);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
`else
    localparam logic PARITY_PRESENT = 1'b0;
`endif

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    uart_state_e  state_q, state_d;
    logic [15:0]  baud_q, baud_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   shift_q, shift_d;
    logic         parity_q, parity_d;
    logic         tx_q, tx_d;
    logic         ovf_q, ovf_d;

    logic [3:0]       offset;
    logic             wr_ok;
    logic             wr_txdata;
    logic             wr_status;
    logic             wr_baud;
    logic [15:0]      baud_wr_val;
    logic             bit_end;
    logic             load_frame;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [31:0]      status_word;
    logic             unused_bits;

    // ---------------- address decode ----------------
    assign offset    = i_bus_address[3:0];
    assign o_bus_hit = (i_bus_address[31:4] == BASE_ADDR[31:4]);
    assign wr_ok     = i_bus_wr_enable && o_bus_hit && wl_valid(i_bus_write_length);
    assign wr_txdata = wr_ok && (offset == OFF_TXDATA);
    assign wr_status = wr_ok && (offset == OFF_STATUS);
    assign wr_baud   = wr_ok && (offset == OFF_BAUD);

    assign unused_bits = ^{i_bus_wr_data[31:16], parity_q};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (wr_txdata),
        .push_data_i (i_bus_wr_data[7:0]),
        .pop_i       (load_frame),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // ---------------- register file ----------------
    always_comb begin
        baud_wr_val = (i_bus_write_length == WL_BYTE) ?
                      {baud_q[15:8], i_bus_wr_data[7:0]} : i_bus_wr_data[15:0];
        baud_d = baud_q;
        if (wr_baud) begin
            baud_d = (baud_wr_val == 16'd0) ? 16'd1 : baud_wr_val;
        end
        ovf_d = ovf_q;
        if (wr_status && i_bus_wr_data[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        status_word                           = '0;
        status_word[STAT_BUSY]                = (state_q != ST_IDLE);
        status_word[STAT_FULL]                = fifo_full;
        status_word[STAT_EMPTY]               = fifo_empty;
        status_word[STAT_OVF]                 = ovf_q;
        status_word[STAT_PARITY]              = PARITY_PRESENT;
        status_word[STAT_LVL_LSB +: 4]        = 4'(fifo_level);
    end

    always_comb begin
        o_bus_read_data = '0;
        if (o_bus_hit) begin
            case (offset)
                OFF_STATUS: o_bus_read_data = status_word;
                OFF_BAUD:   o_bus_read_data = {16'd0, baud_q};
                default:    o_bus_read_data = '0;
            endcase
        end
    end

    // ---------------- transmit FSM ----------------
    // Counter runs BAUD_DIV..1 and reloads from the live divider at every bit boundary.
    assign bit_end = (cnt_q == 16'd1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        load_frame = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? baud_q : (cnt_q - 16'd1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    load_frame = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Starting a frame from IDLE or straight out of STOP: no idle gap.
        if (load_frame) begin
            state_d  = ST_START;
            cnt_d    = baud_q;
            shift_d  = fifo_rd_data;
            parity_d = ^fifo_rd_data;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= DEFAULT_DIV;
            cnt_q     <= 16'd1;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_tx = tx_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: a frame-level reference model compared
// every cycle, plus directed checks with hand-computed values.
module tb_bus_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [31:0] PARBIT = PAR_EN ? 32'h10 : 32'h0;
    localparam int          FRAME4 = PAR_EN ? 44 : 40;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_addr  = BASE;
    logic [31:0] bus_wdata = 32'd0;
    logic        bus_we    = 1'b0;
    logic [2:0]  bus_wl    = 3'd4;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_bus_address      (bus_addr),
        .i_bus_wr_data      (bus_wdata),
        .i_bus_wr_enable    (bus_we),
        .i_bus_write_length (bus_wl),
        .o_bus_read_data    (bus_rdata),
        .o_bus_hit          (bus_hit),
        .o_tx               (tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_fifo[$];
    bit          m_wave[$];
    bit          m_exp_tx = 1'b1;
    bit          m_busy   = 1'b0;
    bit          m_ovf    = 1'b0;
    logic [15:0] m_baud   = 16'd434;

    task automatic build_frame(input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(b[j]);
        if (PAR_EN) bits.push_back(^b);
        bits.push_back(1'b1);
        foreach (bits[j])
            for (int r = 0; r < int'(m_baud); r++) m_wave.push_back(bits[j]);
    endtask

    task automatic model_step();
        bit          full_pre;
        bit          wr;
        logic [15:0] v;
        full_pre = (m_fifo.size() == DEPTH);
        wr = bus_we && (bus_addr[31:4] == BASE[31:4]) &&
             (bus_wl == 3'd1 || bus_wl == 3'd2 || bus_wl == 3'd4);
        if (m_wave.size() == 0 && m_fifo.size() > 0) build_frame(m_fifo.pop_front());
        if (m_wave.size() > 0) begin
            m_exp_tx = m_wave.pop_front();
            m_busy   = 1'b1;
        end else begin
            m_exp_tx = 1'b1;
            m_busy   = 1'b0;
        end
        if (wr) begin
            case (bus_addr[3:0])
                4'h0: if (full_pre) m_ovf = 1'b1; else m_fifo.push_back(bus_wdata[7:0]);
                4'h4: if (bus_wdata[3]) m_ovf = 1'b0;
                4'h8: begin
                    v = (bus_wl == 3'd1) ? {m_baud[15:8], bus_wdata[7:0]} : bus_wdata[15:0];
                    m_baud = (v == 16'd0) ? 16'd1 : v;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_read();
        logic [31:0] st;
        int          lvl;
        lvl = m_fifo.size();
        st = {20'd0, 4'(lvl), 3'd0, PAR_EN, m_ovf, (lvl == 0), (lvl == DEPTH), m_busy};
        if (bus_addr[31:4] != BASE[31:4]) return 32'd0;
        if (bus_addr[3:0] == 4'h4) return st;
        if (bus_addr[3:0] == 4'h8) return {16'd0, m_baud};
        return 32'd0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_fifo.delete();
                m_wave.delete();
                m_exp_tx = 1'b1;
                m_busy   = 1'b0;
                m_ovf    = 1'b0;
                m_baud   = 16'd434;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                check("cyc_tx", {31'd0, tx}, {31'd0, m_exp_tx});
                check("cyc_hit", {31'd0, bus_hit}, {31'd0, bus_addr[31:4] == BASE[31:4]});
                check("cyc_rdata", bus_rdata, model_read());
            end
        end
    end

    // ---------------- drivers (called at posedge+2) ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
        bus_addr  = a;
        bus_wdata = d;
        bus_wl    = l;
        bus_we    = 1'b1;
        @(posedge clk);
        #2;
        bus_we = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_addr = a;
        @(negedge clk);
        check(name, bus_rdata, exp);
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset_pulse(input logic exp_tx_before);
        #4;
        check("pre_reset_tx", {31'd0, tx}, {31'd0, exp_tx_before});
        reset = 1'b1;
        #1;
        check("async_reset_tx", {31'd0, tx}, 32'd1);
        bus_addr = BASE + 32'h4;
        #1;
        check("async_reset_status", bus_rdata, 32'h4 | PARBIT);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Hand-computed serial pattern for 0xA5: start, LSB-first data, [parity], stop.
`ifdef UART_TX_PARITY_EN
    bit a5_bits[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    bit a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

    initial begin
        int busy_cnt;
        int first_idle;
        int low_cnt;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // 1. Reset defaults
        expect_reg("reset_status", BASE + 32'h4, 32'h4 | PARBIT);
        expect_reg("reset_baud", BASE + 32'h8, 32'd434);
        check("reset_tx", {31'd0, tx}, 32'd1);

        // 2. Single frame 0xA5 at BAUD_DIV=4
        bus_write(BASE + 32'h8, 32'd4, 3'd4);
        bus_write(BASE + 32'h0, 32'hA5, 3'd1);
        bus_addr = BASE + 32'h4;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_rdata[0]) busy_cnt++;
            if (i >= 3 && (i - 3) % 4 == 0 && (i - 3) / 4 < $size(a5_bits))
                check($sformatf("a5_bit%0d", (i - 3) / 4), {31'd0, tx},
                      {31'd0, a5_bits[(i - 3) / 4]});
        end
        check("a5_busy_cycles", busy_cnt, FRAME4);
        @(posedge clk);
        #2;

        // 3. Back-to-back frames
        bus_write(BASE, 32'h01, 3'd1);
        bus_write(BASE, 32'h02, 3'd1);
        bus_write(BASE, 32'h03, 3'd1);
        bus_addr   = BASE + 32'h4;
        busy_cnt   = 0;
        first_idle = -1;
        for (int i = 0; i < 3 * FRAME4 + 20; i++) begin
            @(negedge clk);
            if (i == 0) check("b2b_level", {28'd0, bus_rdata[11:8]}, 32'd2);
            if (bus_rdata[0]) busy_cnt++;
            else if (first_idle < 0) first_idle = i;
        end
        check("b2b_busy_cycles", busy_cnt, 3 * FRAME4 - 1);
        check("b2b_first_idle", first_idle, 3 * FRAME4 - 1);
        @(posedge clk);
        #2;

        // 5. Decode and length rules
        bus_write(BASE + 32'h8, 32'h0000_0500, 3'd4);
        bus_write(BASE + 32'h8, 32'h0000_1234, 3'd1);
        expect_reg("baud_byte_write", BASE + 32'h8, 32'h0534);
        bus_write(BASE + 32'h8, 32'h0000_0077, 3'd3);
        bus_write(BASE + 32'h8, 32'h0000_0099, 3'd0);
        expect_reg("baud_bad_length", BASE + 32'h8, 32'h0534);
        bus_write(BASE + 32'h8, 32'h0000_0000, 3'd2);
        expect_reg("baud_zero_is_one", BASE + 32'h8, 32'h1);
        bus_write(BASE + 32'h8, 32'hFFFF_0000, 3'd4);
        expect_reg("baud_word_zero_low", BASE + 32'h8, 32'h1);
        bus_write(BASE + 32'h8, 32'd4, 3'd2);
        bus_addr = BASE + 32'h10;
        @(negedge clk);
        check("hit_above_window", {31'd0, bus_hit}, 32'd0);
        @(posedge clk);
        #2;
        bus_write(BASE + 32'h10, 32'h55, 3'd1);
        bus_write(BASE + 32'h1, 32'h55, 3'd1);
        bus_write(BASE + 32'hC, 32'h55, 3'd4);
        bus_write(BASE + 32'h0, 32'h55, 3'd3);
        expect_reg("ignored_pushes_status", BASE + 32'h4, 32'h4 | PARBIT);
        expect_reg("txdata_reads_zero", BASE + 32'h0, 32'h0);
        expect_reg("offset_c_reads_zero", BASE + 32'hC, 32'h0);

        // 4. Overflow
        bus_write(BASE + 32'h8, 32'd100, 3'd4);
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + i, 3'd1);
        expect_reg("ovf_status", BASE + 32'h4, 32'h80B | PARBIT);
        bus_write(BASE + 32'h4, 32'h8, 3'd4);
        expect_reg("ovf_cleared", BASE + 32'h4, 32'h803 | PARBIT);
        async_reset_pulse(1'b0);
        expect_reg("post_reset_baud", BASE + 32'h8, 32'd434);

        // 6. Asynchronous reset mid-DATA of frame 2 of 3
        bus_write(BASE + 32'h8, 32'd4, 3'd4);
        bus_write(BASE, 32'h01, 3'd1);
        bus_write(BASE, 32'h00, 3'd1);
        bus_write(BASE, 32'h03, 3'd1);
        repeat (49) @(posedge clk);
        #2;
        async_reset_pulse(1'b0);
        expect_reg("after_abort_status", BASE + 32'h4, 32'h4 | PARBIT);
        low_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        check("no_frames_after_abort", low_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
